// File: rtl/lemming_pkg.sv
// Shared types and defaults for the lemming walker environment model.
// Input one-hot order is {walk_left, walk_right, aaah, digging}.
package lemming_pkg;

  localparam int unsigned DEF_COLS       = 16;
  localparam int unsigned DEF_MAX_LVL    = 7;
  localparam int unsigned DEF_DIG_CYCLES = 2;
  localparam int unsigned DEF_START_X    = 8;
  localparam int unsigned DEF_SPLAT_LIM  = 4;

  typedef logic [3:0] fsm_in_t;

  typedef enum logic [3:0] {
    IN_IDLE  = 4'b0000,
    IN_DIG   = 4'b0001,
    IN_AAAH  = 4'b0010,
    IN_RIGHT = 4'b0100,
    IN_LEFT  = 4'b1000
  } fsm_cmd_e;

  // True when two or more FSM outputs are high at once.
  function automatic logic multi_hot(input fsm_in_t v);
    return (v & (v - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/lemming_terrain.sv
// Per-column floor depth store: one cfg write port, one dig-increment port,
// and two combinational read ports (current column and its neighbour).
module lemming_terrain
  import lemming_pkg::*;
#(
  parameter int unsigned COLS    = DEF_COLS,
  parameter int unsigned MAX_LVL = DEF_MAX_LVL,
  parameter int unsigned XW      = 4,
  parameter int unsigned YW      = 3
)(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cfg_we,
  input  logic [XW-1:0] cfg_x,
  input  logic [YW-1:0] cfg_lvl,
  input  logic          inc_en,
  input  logic [XW-1:0] inc_x,
  input  logic [XW-1:0] rd_x,
  input  logic [XW-1:0] rd_nx,
  output logic [YW-1:0] dug_x,
  output logic [YW-1:0] dug_nx
);

  localparam logic [XW:0] COLS_V = (XW + 1)'(COLS);

  logic [YW-1:0] dug [COLS];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < COLS; i++) dug[i] <= '0;
    end else begin
      if (inc_en && ({1'b0, inc_x} < COLS_V)) dug[inc_x] <= dug[inc_x] + YW'(1);
      // Later assignment: a cfg write beats a dig increment on the same column.
      if (cfg_we && ({1'b0, cfg_x} < COLS_V)) dug[cfg_x] <= cfg_lvl;
    end
  end

  assign dug_x  = ({1'b0, rd_x}  < COLS_V) ? dug[rd_x]  : '0;
  assign dug_nx = ({1'b0, rd_nx} < COLS_V) ? dug[rd_nx] : '0;

endmodule

// File: rtl/lemming_world.sv
// Closed-loop terrain/position model feeding the lemming walker FSM.
// Define LEMMING_WORLD_SPLAT_EN to include fall counting and splat/freeze.
module lemming_world
  import lemming_pkg::*;
#(
  parameter int unsigned COLS       = DEF_COLS,
  parameter int unsigned MAX_LVL    = DEF_MAX_LVL,
  parameter int unsigned DIG_CYCLES = DEF_DIG_CYCLES,
  parameter int unsigned START_X    = DEF_START_X,
  parameter int unsigned SPLAT_LIM  = DEF_SPLAT_LIM,
  localparam int unsigned XW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int unsigned YW = (MAX_LVL > 0) ? $clog2(MAX_LVL + 1) : 1
)(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          walk_left,
  input  logic          walk_right,
  input  logic          aaah,
  input  logic          digging,
  input  logic          cfg_we,
  input  logic [XW-1:0] cfg_x,
  input  logic [YW-1:0] cfg_lvl,
  output logic          bump_left,
  output logic          bump_right,
  output logic          ground,
  output logic [XW-1:0] x_pos,
  output logic [YW-1:0] y_pos,
  output logic          splat,
  output logic          err
);

  localparam int unsigned   DW       = $clog2(DIG_CYCLES + 1);
  localparam logic [XW-1:0] X_MAX    = XW'(COLS - 1);
  localparam logic [XW-1:0] X_START  = XW'(START_X);
  localparam logic [YW-1:0] Y_MAX    = YW'(MAX_LVL);
  localparam logic [DW-1:0] DIG_LAST = DW'(DIG_CYCLES - 1);

  if (DIG_CYCLES == 0 || START_X >= COLS || SPLAT_LIM >= 65536) begin : g_bad_params
    $error("lemming_world: unsupported parameter set");
  end

  fsm_in_t       cmd;
  logic [XW-1:0] x, x_n, nx;
  logic [YW-1:0] y, y_n, dug_x, dug_nx, cfg_sat;
  logic [DW-1:0] dig_cnt, dig_n;
  logic          bl_n, br_n, err_n, inc_en, frozen;

`ifdef LEMMING_WORLD_SPLAT_EN
  localparam int unsigned   FW       = $clog2(SPLAT_LIM + 2);
  localparam logic [FW-1:0] FALL_SAT = FW'(SPLAT_LIM + 1);
  localparam logic [FW-1:0] FALL_LIM = FW'(SPLAT_LIM);
  logic [FW-1:0] fall_cnt, fall_n;
  logic          splat_q, splat_n;
  assign frozen = splat_q;
  assign splat  = splat_q;
`else
  assign frozen = 1'b0;
  assign splat  = 1'b0;
`endif

  assign cmd     = {walk_left, walk_right, aaah, digging};
  assign nx      = walk_left ? x - XW'(1) : x + XW'(1);
  assign cfg_sat = (cfg_lvl > Y_MAX) ? Y_MAX : cfg_lvl;
  assign ground  = (y == dug_x);
  assign x_pos   = x;
  assign y_pos   = y;

  lemming_terrain #(.COLS(COLS), .MAX_LVL(MAX_LVL), .XW(XW), .YW(YW)) u_terrain (
    .clk    (clk),
    .reset_n(reset_n),
    .cfg_we (cfg_we),
    .cfg_x  (cfg_x),
    .cfg_lvl(cfg_sat),
    .inc_en (inc_en),
    .inc_x  (x),
    .rd_x   (x),
    .rd_nx  (nx),
    .dug_x  (dug_x),
    .dug_nx (dug_nx)
  );

  always_comb begin
    x_n    = x;
    y_n    = y;
    dig_n  = dig_cnt;
    bl_n   = 1'b0;
    br_n   = 1'b0;
    err_n  = err;
    inc_en = 1'b0;
`ifdef LEMMING_WORLD_SPLAT_EN
    fall_n  = fall_cnt;
    splat_n = splat_q;
`endif
    if (multi_hot(cmd)) begin
      err_n = 1'b1;
    end else if (!frozen) begin
      dig_n = '0;
      case (cmd)
        IN_LEFT: if (ground) begin
          if (x == '0 || dug_nx < y) bl_n = 1'b1;
          else                       x_n  = x - XW'(1);
        end
        IN_RIGHT: if (ground) begin
          if (x == X_MAX || dug_nx < y) br_n = 1'b1;
          else                          x_n  = x + XW'(1);
        end
        IN_AAAH: begin
          if (!ground) begin
            y_n = y + YW'(1);
`ifdef LEMMING_WORLD_SPLAT_EN
            if (fall_cnt != FALL_SAT) fall_n = fall_cnt + FW'(1);
`endif
          end else begin
`ifdef LEMMING_WORLD_SPLAT_EN
            if (fall_cnt > FALL_LIM) splat_n = 1'b1;
            fall_n = '0;
`endif
          end
        end
        IN_DIG: if (ground && dug_x < Y_MAX) begin
          if (dig_cnt == DIG_LAST) inc_en = 1'b1;
          else                     dig_n  = dig_cnt + DW'(1);
        end
        default: ;
      endcase
    end
    // Clamp against the column the lemming ends up in, keeping y <= dug[x].
    if (cfg_we && cfg_x == x_n && cfg_sat < y_n) y_n = cfg_sat;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x          <= X_START;
      y          <= '0;
      dig_cnt    <= '0;
      bump_left  <= 1'b0;
      bump_right <= 1'b0;
      err        <= 1'b0;
`ifdef LEMMING_WORLD_SPLAT_EN
      fall_cnt   <= '0;
      splat_q    <= 1'b0;
`endif
    end else begin
      x          <= x_n;
      y          <= y_n;
      dig_cnt    <= dig_n;
      bump_left  <= bl_n;
      bump_right <= br_n;
      err        <= err_n;
`ifdef LEMMING_WORLD_SPLAT_EN
      fall_cnt   <= fall_n;
      splat_q    <= splat_n;
`endif
    end
  end

endmodule

// File: doc/lemming_world.md
# lemming_world

Closed-loop terrain and position model for the lemming walker FSM. Consumes the FSM's one-hot Moore outputs (walk_left, walk_right, aaah, digging) and returns the FSM's environment inputs (bump_left, bump_right, ground). It tracks position, per-column dig depth, fall length and death. Used as the environment stage in system benches and the demo top.

## Interface
Parameters:
- COLS, 16: number of columns; walls sit beyond x=0 and x=COLS-1.
- MAX_LVL, 7: bedrock level; a column cannot be dug deeper than this.
- DIG_CYCLES, 2: consecutive digging cycles needed to remove one level.
- START_X, 8: x position at reset.
- SPLAT_LIM, 4: a fall longer than this many levels kills the lemming.
- XW / YW: derived, clog2(COLS) / clog2(MAX_LVL+1). Not user-set.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; one clock, synchronous, active-low.
- walk_left, walk_right, aaah, digging  in  1 each  FSM state outputs; at most one is high.
- cfg_we  in  1  terrain write strobe.
- cfg_x  in  XW  column to write.
- cfg_lvl  in  YW  new floor depth for that column; values above MAX_LVL saturate to MAX_LVL.
- bump_left, bump_right  out  1  registered one-cycle bump pulses.
- ground  out  1  lemming stands on floor; combinational from registered state only.
- x_pos  out  XW  current column.
- y_pos  out  YW  current level; 0 is the surface, larger is deeper.
- splat  out  1  sticky; lemming dead.
- err  out  1  sticky protocol error.

## Operation
- State: x, y, dug[COLS] (floor depth per column), dig_cnt, fall_cnt, splat, err.
- ground = (y == dug[x]). The invariant y ≤ dug[x] always holds.
- Walk: walk_left with ground=1:
  - Blocked if x==0 or dug[x-1] < y (the neighbour's floor is higher, forming a step wall).
  - If blocked: x holds and bump_left=1 for the next cycle only.
  - Else x−1, y unchanged.
  - walk_right is the mirror case, using x==COLS-1 and dug[x+1].
  - Walking onto a deeper column leaves ground=0.
- Walk with ground=0: no motion. The FSM lags by one cycle; this case is not an error.
- Dig: digging with ground=1 and dug[x] < MAX_LVL increments dig_cnt.
  - When dig_cnt reaches DIG_CYCLES-1: dug[x]+1 and dig_cnt←0.
  - dig_cnt clears on any cycle without digging.
  - At MAX_LVL, digging has no effect and ground stays 1.
- Fall: aaah with ground=0 gives y+1 and fall_cnt+1, saturating at SPLAT_LIM+1.
  - aaah with ground=1 is the landing cycle: if fall_cnt > SPLAT_LIM then splat←1; fall_cnt←0 regardless.
- All-zero inputs: idle, state holds.
- Two or more of the four inputs high: err←1; x, y, dug and counters hold that cycle.
- Dead: when splat=1, x, y, dug and counters freeze; bumps stay 0; cfg writes are still accepted.
- cfg_we writes dug[cfg_x].
  - If cfg_x == x and the write makes dug[x] < y, y is clamped to dug[x].
  - cfg wins over a simultaneous dig increment to the same column.

## Timing
- All state updates on the rising edge of clk; inputs are sampled on that edge.
- bump_left and bump_right are high exactly the one cycle after the blocked walk sample.
- ground, x_pos and y_pos reflect the new state in the same cycle after the edge.
- There is no combinational path from any input to any output; this keeps the FSM loop legal.
- Reset values: x=START_X, y=0, dug all 0, dig_cnt=0, fall_cnt=0, bump_left=bump_right=0, ground=1, splat=0, err=0.
- Reset has priority over all activity, including a reset asserted mid-fall or mid-dig.

## Configuration
- LEMMING_WORLD_SPLAT_EN defined: fall_cnt and the splat/freeze logic are present, as described above.
- Not defined: no fall_cnt, splat tied to 0, lemming never freezes; SPLAT_LIM is unused.

## Structure
- Shared package lemming_pkg holds:
  - the input one-hot encoding as a 4-bit typedef in the order {walk_left, walk_right, aaah, digging};
  - a helper function for the protocol check;
  - default parameter constants.
- One sub-module, lemming_terrain: the dug[] register array, with a cfg write port, a dig-increment port and two combinational read ports (x and a neighbour).
- Motion, dig, fall and error logic stay in the top.

## Test plan
All scenarios use default parameters.
1. Reset, then walk_left for 9 cycles → x_pos steps 8→0 over 8 cycles; the 9th sample is blocked; bump_left=1 for exactly one cycle; x_pos stays 0.
2. digging for 2 cycles at x=8 → dug[8]=1 and ground=0. Then aaah for 1 cycle → y_pos=1, ground=1. Then walk_right → bump_right pulse (dug[9]=0 < 1); x_pos stays 8.
3. cfg dug[9]=5, then walk_right from x=8 → x_pos=9, ground=0. Then 5 aaah cycles → y_pos=5, ground=1. Landing cycle → splat=1. Further walk_right → x_pos stays 9. With the macro undefined, splat stays 0.
4. cfg dug[8]=7, lemming at y=7 (fall 7 levels; macro off), then digging for 6 cycles → dug stays 7, ground=1, y_pos=7.
5. walk_left and digging both high for one cycle at x=8 → err=1, x_pos=8, dug[8]=0. Then single walk_left → x_pos=7 and err stays 1.
6. reset_n low for one cycle during the 3rd aaah cycle of a fall → next cycle x_pos=8, y_pos=0, ground=1, dug all 0, splat=0, err=0.
